// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the native valid/ready memory bus, registered grant held per transaction.
// Optional watchdog under MEM_ARB_TIMEOUT_EN: forces completion with 32'hDEADBEEF after TIMEOUT_CYCLES owned cycles.
module mem_bus_arbiter #(
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state, state_nxt;
  logic   last_owner;   // 1 = m1 owned the most recent completed transaction
  logic   tmo_hit;
  logic   done;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (state != IDLE) && !s_ready && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Counter is zero in IDLE, so every ownership starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == IDLE) ? 16'd0 : tmo_cnt + 16'd1;
      if (tmo_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  logic unused_tmo_param;
  assign unused_tmo_param = ^TIMEOUT_CYCLES;
  assign tmo_hit          = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  assign grant = {state == OWN1, state == OWN0};
  assign done  = (state != IDLE) && (s_ready || tmo_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (done)
        last_owner <= (state == OWN1);
    end
  end

  always_comb begin
    state_nxt = state;
    s_valid   = 1'b0;
    s_instr   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    case (state)
      IDLE: begin
        if (m0_valid && m1_valid)
          state_nxt = (FIXED_PRIO != 0 || last_owner) ? OWN0 : OWN1;
        else if (m0_valid)
          state_nxt = OWN0;
        else if (m1_valid)
          state_nxt = OWN1;
      end
      OWN0: begin
        s_valid  = m0_valid && !tmo_hit;
        s_instr  = m0_instr;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready || tmo_hit;
        m0_rdata = tmo_hit ? 32'hDEADBEEF : s_rdata;
        // A master that withdraws its request abandons the transaction.
        if (done || !m0_valid)
          state_nxt = IDLE;
      end
      OWN1: begin
        s_valid  = m1_valid && !tmo_hit;
        s_instr  = m1_instr;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready || tmo_hit;
        m1_rdata = tmo_hit ? 32'hDEADBEEF : s_rdata;
        if (done || !m1_valid)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: round-robin (d[0]) and fixed-priority (d[1]) instances share one stimulus stream.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam int TC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_instr, m1_valid, m1_instr, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic [31:0] o_m0_rdata [2];
  logic [31:0] o_m1_rdata [2];
  logic [31:0] o_s_addr   [2];
  logic [31:0] o_s_wdata  [2];
  logic [3:0]  o_s_wstrb  [2];
  logic [1:0]  o_grant    [2];
  logic        o_m0_ready [2];
  logic        o_m1_ready [2];
  logic        o_s_valid  [2];
  logic        o_s_instr  [2];
  logic        o_tmo_err  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_bus_arbiter #(.FIXED_PRIO(g), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rdata(o_m0_rdata[g]), .m0_ready(o_m0_ready[g]),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rdata(o_m1_rdata[g]), .m1_ready(o_m1_ready[g]),
      .s_valid(o_s_valid[g]), .s_instr(o_s_instr[g]), .s_addr(o_s_addr[g]),
      .s_wdata(o_s_wdata[g]), .s_wstrb(o_s_wstrb[g]), .s_rdata(s_rdata), .s_ready(s_ready),
      .grant(o_grant[g]), .timeout_err(o_tmo_err[g])
    );
  end

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL d%0d %s: got %h expected %h at %0t", inst, name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: who owns the bus (-1 none), who was served last, cycles spent owning, sticky error.
  int owner [2];
  int last  [2];
  int cnt   [2];
  bit err   [2];
  int served0[$];
  int served1[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e_rd0, e_rd1, e_addr, e_wdata;
      logic [3:0]  e_wstrb;
      logic [1:0]  e_g;
      logic        e_sv, e_si, e_r0, e_r1, vx, to;
      if (rst) begin
        owner[i] = -1; last[i] = 1; cnt[i] = 0; err[i] = 1'b0;
      end
      e_rd0 = 0; e_rd1 = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0; e_g = 2'b00;
      e_sv = 0; e_si = 0; e_r0 = 0; e_r1 = 0; vx = 0; to = 0;
      if (owner[i] >= 0) begin
        to = TMO && !s_ready && (cnt[i] == TC - 1);
        vx = (owner[i] == 1) ? m1_valid : m0_valid;
        e_g     = (owner[i] == 1) ? 2'b10 : 2'b01;
        e_sv    = vx && !to;
        e_si    = (owner[i] == 1) ? m1_instr : m0_instr;
        e_addr  = (owner[i] == 1) ? m1_addr  : m0_addr;
        e_wdata = (owner[i] == 1) ? m1_wdata : m0_wdata;
        e_wstrb = (owner[i] == 1) ? m1_wstrb : m0_wstrb;
        if (owner[i] == 1) begin
          e_r1 = s_ready || to; e_rd1 = to ? 32'hDEADBEEF : s_rdata;
        end else begin
          e_r0 = s_ready || to; e_rd0 = to ? 32'hDEADBEEF : s_rdata;
        end
      end
      chk(i, "grant",    {30'd0, o_grant[i]}, {30'd0, e_g});
      chk(i, "s_valid",  {31'd0, o_s_valid[i]}, {31'd0, e_sv});
      chk(i, "s_instr",  {31'd0, o_s_instr[i]}, {31'd0, e_si});
      chk(i, "s_addr",   o_s_addr[i], e_addr);
      chk(i, "s_wdata",  o_s_wdata[i], e_wdata);
      chk(i, "s_wstrb",  {28'd0, o_s_wstrb[i]}, {28'd0, e_wstrb});
      chk(i, "m0_ready", {31'd0, o_m0_ready[i]}, {31'd0, e_r0});
      chk(i, "m1_ready", {31'd0, o_m1_ready[i]}, {31'd0, e_r1});
      chk(i, "m0_rdata", o_m0_rdata[i], e_rd0);
      chk(i, "m1_rdata", o_m1_rdata[i], e_rd1);
      chk(i, "tmo_err",  {31'd0, o_tmo_err[i]}, {31'd0, err[i]});
      if (!rst) begin
        if (owner[i] < 0) begin
          cnt[i] = 0;
          if (m0_valid && m1_valid) owner[i] = (i == 1) ? 0 : 1 - last[i];
          else if (m0_valid)        owner[i] = 0;
          else if (m1_valid)        owner[i] = 1;
        end else if (s_ready || to) begin
          if (to) err[i] = 1'b1;
          if (i == 0) served0.push_back(owner[i]); else served1.push_back(owner[i]);
          last[i]  = owner[i];
          owner[i] = -1;
        end else if (!vx) begin
          owner[i] = -1;
        end else begin
          cnt[i]++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; s_ready = 0; s_rdata = 0;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst grant",   {30'd0, o_grant[i]}, 32'd0);
      chk(i, "rst s_valid", {31'd0, o_s_valid[i]}, 32'd0);
      chk(i, "rst tmo_err", {31'd0, o_tmo_err[i]}, 32'd0);
    end
    rst = 1'b0;
    tick();

    // m0 read, slave answers after two wait cycles
    m0_valid = 1; m0_addr = 32'h0000_0100;
    tick();
    chk(0, "t1 grant", {30'd0, o_grant[0]}, 32'd1);
    chk(0, "t1 s_valid", {31'd0, o_s_valid[0]}, 32'd1);
    tick(); tick();
    s_ready = 1; s_rdata = 32'h1234_5678;
    #1;
    chk(0, "t1 m0_ready", {31'd0, o_m0_ready[0]}, 32'd1);
    chk(0, "t1 m0_rdata", o_m0_rdata[0], 32'h1234_5678);
    chk(0, "t1 m1_ready", {31'd0, o_m1_ready[0]}, 32'd0);
    tick();
    s_ready = 0; m0_valid = 0;
    chk(0, "t1 idle grant", {30'd0, o_grant[0]}, 32'd0);
    tick();

    // Both masters request continuously from reset
    rst = 1'b1; tick(); rst = 1'b0;
    served0.delete(); served1.delete();
    m0_valid = 1; m1_valid = 1; m1_addr = 32'h0000_0200;
    tick();
    for (int k = 0; k < 4; k++) begin
      s_ready = 1; s_rdata = 32'h100 + k;
      tick();
      s_ready = 0;
      if (k == 3) begin m0_valid = 0; m1_valid = 0; end
      tick();
    end
    chk(0, "rr count", served0.size(), 32'd4);
    chk(1, "fp count", served1.size(), 32'd4);
    if (served0.size() == 4 && served1.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk(0, $sformatf("rr owner%0d", k), served0[k], k % 2);
        chk(1, $sformatf("fp owner%0d", k), served1[k], 32'd0);
      end

    // m1 write; m0 fields hold junk but m0 is idle
    m0_addr = 32'hDEAD_0000; m0_wdata = 32'h55; m0_wstrb = 4'b0011; m0_instr = 1;
    m1_valid = 1; m1_addr = 32'h2000_0000; m1_wdata = 32'h3F; m1_wstrb = 4'b1111; m1_instr = 0;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t4 grant",   {30'd0, o_grant[i]}, 32'd2);
      chk(i, "t4 s_addr",  o_s_addr[i], 32'h2000_0000);
      chk(i, "t4 s_wdata", o_s_wdata[i], 32'h0000_003F);
      chk(i, "t4 s_wstrb", {28'd0, o_s_wstrb[i]}, 32'hF);
    end
    tick();
    s_ready = 1; s_rdata = 32'hCAFE_0001;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "t4 m1_ready", {31'd0, o_m1_ready[i]}, 32'd1);
      chk(i, "t4 m0_ready", {31'd0, o_m0_ready[i]}, 32'd0);
      chk(i, "t4 m0_rdata", o_m0_rdata[i], 32'd0);
    end
    tick();
    s_ready = 0; m1_valid = 0;
    tick();

    // Reset while m1 waits on the slave
    m1_valid = 1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "t5 s_valid", {31'd0, o_s_valid[i]}, 32'd0);
      chk(i, "t5 grant",   {30'd0, o_grant[i]}, 32'd0);
    end
    tick();
    rst = 1'b0; m0_valid = 1;
    tick();
    for (int i = 0; i < 2; i++)
      chk(i, "t5 tie grant", {30'd0, o_grant[i]}, 32'd1);
    s_ready = 1;
    tick();
    s_ready = 0; m0_valid = 0; m1_valid = 0;
    tick();

    // Slave never answers an m0 request
    m0_valid = 1;
    tick();
`ifdef MEM_ARB_TIMEOUT_EN
    repeat (TC - 1) tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t6 m0_ready", {31'd0, o_m0_ready[i]}, 32'd1);
      chk(i, "t6 m0_rdata", o_m0_rdata[i], 32'hDEAD_BEEF);
      chk(i, "t6 s_valid",  {31'd0, o_s_valid[i]}, 32'd0);
    end
    tick();
    m0_valid = 0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t6 grant",   {30'd0, o_grant[i]}, 32'd0);
      chk(i, "t6 tmo_err", {31'd0, o_tmo_err[i]}, 32'd1);
    end
`else
    repeat (30) tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t6 grant held", {30'd0, o_grant[i]}, 32'd1);
      chk(i, "t6 tmo_err",    {31'd0, o_tmo_err[i]}, 32'd0);
    end
    s_ready = 1;
    tick();
    s_ready = 0; m0_valid = 0;
    tick();
`endif
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
